// File: rtl/din_event_conditioner.sv
// ---------------------------------------------------------------------------
// din_event_conditioner
//   Multi-channel digital-input front end. Each channel's raw input goes
//   through a two-flop synchroniser and a debounce filter with a
//   programmable stability count. The filter produces rise/fall pulses, and
//   selected edges are counted in wrapping event counters. A snapshot
//   register captures every counter on the same edge so that the register
//   bank can read a coherent set of values.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   din        : [N_CH] asynchronous raw inputs
//   deb_limit  : [DEB_W] debounce limit L, shared, quasi-static
//   edge_mode  : [2*N_CH] per channel {count_fall, count_rise}
//   clr_cnt    : strobe, clears all event counters (wins over increments)
//   snap       : strobe, latches all event counters into snap_cnt
//   dout       : [N_CH] debounced level
//   rise/fall  : [N_CH] one-cycle pulses on debounced transitions
//   ev_cnt     : [N_CH*EV_W] live counters, channel i at [EV_W*i +: EV_W]
//   snap_cnt   : [N_CH*EV_W] snapshot counters, same packing
//   snap_valid : one-cycle pulse the cycle after snap
// ---------------------------------------------------------------------------

// Per-channel lane: synchroniser, debounce filter, edge pulses, event counter.
module din_event_lane #(
   parameter int DEB_W = 16,
   parameter int EV_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic [DEB_W-1:0] deb_limit,
   input  logic [1:0]       edge_mode,
   input  logic             clr_cnt,
   output logic             dout,
   output logic             rise,
   output logic             fall,
   output logic [EV_W-1:0]  ev_cnt
);

   logic             s1, s2;
   logic [DEB_W-1:0] cnt;
   logic             ev_inc;

   // Counting uses the registered pulses, so the counter moves on the edge
   // that ends the pulse cycle. edge_mode is sampled on that same edge.
   assign ev_inc = (rise & edge_mode[0]) | (fall & edge_mode[1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         dout   <= 1'b0;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         ev_cnt <= '0;
      end else begin
         s1   <= din;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;

         // The >= compare means a lowered limit takes effect at once, and
         // cnt can never exceed the limit, so it cannot wrap.
         if (s2 == dout) begin
            cnt <= '0;
         end else if (cnt >= deb_limit) begin
            dout <= s2;
            cnt  <= '0;
            rise <= s2;
            fall <= ~s2;
         end else begin
            cnt <= cnt + DEB_W'(1);
         end

         // Clear beats a coincident increment; that event is dropped.
         if (clr_cnt)
            ev_cnt <= '0;
         else if (ev_inc)
            ev_cnt <= ev_cnt + EV_W'(1);
      end
   end

endmodule

module din_event_conditioner #(
   parameter int N_CH  = 2,
   parameter int DEB_W = 16,
   parameter int EV_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH-1:0]      din,
   input  logic [DEB_W-1:0]     deb_limit,
   input  logic [2*N_CH-1:0]    edge_mode,
   input  logic                 clr_cnt,
   input  logic                 snap,
   output logic [N_CH-1:0]      dout,
   output logic [N_CH-1:0]      rise,
   output logic [N_CH-1:0]      fall,
   output logic [N_CH*EV_W-1:0] ev_cnt,
   output logic [N_CH*EV_W-1:0] snap_cnt,
   output logic                 snap_valid
);

   // Packed so that element i lands at [EV_W*i +: EV_W] of the flat bus.
   logic [N_CH-1:0][EV_W-1:0] ev_arr;

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      din_event_lane #(
         .DEB_W (DEB_W),
         .EV_W  (EV_W)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .din       (din[i]),
         .deb_limit (deb_limit),
         .edge_mode (edge_mode[2*i +: 2]),
         .clr_cnt   (clr_cnt),
         .dout      (dout[i]),
         .rise      (rise[i]),
         .fall      (fall[i]),
         .ev_cnt    (ev_arr[i])
      );
   end

   assign ev_cnt = ev_arr;

   // Snapshot takes the pre-edge counter values, so a coincident increment
   // or clear is not visible in it.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_cnt   <= '0;
         snap_valid <= 1'b0;
      end else begin
         snap_valid <= snap;
         if (snap)
            snap_cnt <= ev_arr;
      end
   end

endmodule

// File: doc/din_event_conditioner.md
Name: din_event_conditioner

Overview:
- Parametrised multi-channel digital-input front end for the RPH control logic.
- Per channel: synchronise an asynchronous input, debounce it with a programmable stability count, and generate rise/fall pulses.
- Counts selected edges in wrapping event counters.
- Provides a coherent snapshot of all counters for register-bank readout.

Parameters:
- N_CH, 2, number of input channels.
- DEB_W, 16, width of debounce limit and per-channel debounce counter.
- EV_W, 32, width of each event counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  N_CH  asynchronous raw inputs; bit i = channel i.
- deb_limit  in  DEB_W  debounce limit L, shared by all channels, quasi-static.
- edge_mode  in  2*N_CH  per channel, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- clr_cnt  in  1  one-cycle strobe; clears all event counters.
- snap  in  1  one-cycle strobe; latches all event counters into snap_cnt.
- dout  out  N_CH  debounced level.
- rise  out  N_CH  one-cycle pulse on debounced 0->1.
- fall  out  N_CH  one-cycle pulse on debounced 1->0.
- ev_cnt  out  N_CH*EV_W  live event counters; channel i at [EV_W*i +: EV_W].
- snap_cnt  out  N_CH*EV_W  snapshot counters; same packing as ev_cnt.
- snap_valid  out  1  one-cycle pulse, asserted the cycle after snap.

Behaviour:
- Reset (rst=1 at a clock edge): sync flops, dout, debounce counters, rise, fall, ev_cnt, snap_cnt and snap_valid all go to 0.
  - rst overrides every other input.
  - Mid-operation reset discards any pending debounce and any snap.
- Synchroniser: two flops per channel, s1 <= din, s2 <= s1. No other logic touches din.
- Debounce, per channel, with counter cnt:
  - If s2 == dout: cnt <= 0.
  - If s2 != dout and cnt >= L: dout <= s2, cnt <= 0.
  - If s2 != dout and cnt < L: cnt <= cnt+1.
- Debounce consequences:
  - dout updates on the (L+1)th consecutive cycle of disagreement.
  - L=0 gives 1-cycle debounce.
  - Latency from a stable din change to dout change = 2 + L + 1 clock edges.
  - A glitch shorter than L+1 cycles at s2 never reaches dout; cnt restarts from 0 after it.
  - L is compared with >=, so lowering L mid-count takes effect immediately, with no overflow.
  - cnt never exceeds L, so no wrap is possible.
- Edge pulses: rise[i]/fall[i] are registered and asserted in the same cycle dout[i] changes, for exactly one cycle. Channels are fully independent; simultaneous edges on several channels are all reported.
- Event counters, per channel:
  - Increment by 1 in the cycle after the rise/fall pulse when that edge type is enabled by edge_mode.
  - Wrap modulo 2^EV_W: all-ones + 1 -> 0, no flag.
  - edge_mode changes take effect on the next pulse.
- clr_cnt: all ev_cnt <= 0 on that edge. clr_cnt wins over a same-cycle increment, and that event is lost.
- snap:
  - All snap_cnt <= ev_cnt, taken from the pre-edge values, on one clock edge for all channels.
  - A same-cycle increment or clear is not visible in the snapshot.
  - snap_valid pulses in the following cycle; snap_cnt holds until the next snap or rst.
  - Back-to-back snaps are each honoured.
- No handshake back-pressure: strobes are single-cycle and level-insensitive beyond the cycle they are sampled.

Test Plan:
- Reset/latency: N_CH=2, L=3; din[0] 0->1 and held → dout[0]=1 exactly 6 edges later; rise[0] high one cycle in that same cycle; all outputs 0 during and after rst.
- Glitch rejection: L=3; din[1] pulses high 3 cycles, then 0 → dout[1], rise, fall and ev_cnt stay 0. A 4-cycle pulse (aligned at s2) produces rise then fall.
- Edge modes: edge_mode=01 on ch0, 11 on ch1; apply 5 full pulses to both → ev_cnt ch0=5, ch1=10; edge_mode=00 → no further change.
- Wrap and clear: preload via 2^EV_W edges in a reduced-width build (EV_W=4, 16 rises) → ev_cnt ch0 reads 0. clr_cnt in the same cycle as an increment → 0, not 1.
- Snapshot coherence: counters at ch0=7, ch1=3; snap in the same cycle as a counted ch0 edge → snap_cnt = {3,7}, ev_cnt ch0 = 8 afterwards; snap_valid one cycle later. snap+clr together → snap = {3,7}, ev_cnt = 0.
- Reset mid-debounce: L=100, rst asserted at cnt=50 → dout=0, cnt=0. After release, full L+1 cycles are required again.
